load_store_unit: RTL
====================

# load_store_unit

Load/store unit between the execute stage and data memory of the RV32I core. Accepts one memory operation at a time (effective address from the ALU, store data from the register file's store-data read port) and runs a valid/ready transaction on the data-memory bus. Returns aligned, sign- or zero-extended load data as a write-back to the register file's memory write input. Stalls the pipeline while a transaction is outstanding.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: execute stage presents a memory op.
- `req_ready`  out  1: unit can accept; high only in IDLE.
- `req_load`  in  1: 1 = load, 0 = store.
- `req_funct3`  in  3: loads use LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores use SB 000, SH 001, SW 010.
- `req_addr`  in  ADDR_W: byte effective address.
- `req_wdata`  in  32: store data (low bits significant).
- `req_rd`  in  5: load destination register.
- `mem_valid`  out  1: bus request.
- `mem_ready`  in  1: bus accepts request.
- `mem_we`  out  1: 1 = write.
- `mem_addr`  out  ADDR_W: word-aligned address (bits [1:0] = 0).
- `mem_wstrb`  out  4: byte enables.
- `mem_wdata`  out  32: lane-replicated store data.
- `mem_rvalid`  in  1: read data valid.
- `mem_rdata`  in  32: read word.
- `wb_valid`  out  1: one-cycle write-back pulse.
- `wb_rd`  out  5: write-back register.
- `wb_data`  out  32: extended load data.
- `stall`  out  1: high whenever state is not IDLE.
- `err`  out  1: one-cycle pulse for a misaligned or illegal op.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - REQ: `mem_valid` held until `mem_ready`.
  - RESP: load waiting for `mem_rvalid`.
- Accept when `req_valid` && `req_ready`. The op, address, funct3, rd, strobe and formatted data are registered at acceptance.
- Legality is checked at acceptance. An op is illegal if any of these hold:
  - LH/LHU/SH with `addr[0]` = 1.
  - LW/SW with `addr[1:0]` != 0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- An illegal op produces an `err` pulse the next cycle. The FSM stays in IDLE, there is no bus access and no write-back.
- A legal op moves the FSM IDLE→REQ.
- REQ: `mem_valid`, `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` are stable until `mem_ready`.
  - On handshake, a store goes to IDLE.
  - On handshake, a load goes to RESP.
- Store formatting:
  - SB: `mem_wstrb` = 1 << `addr[1:0]`, `mem_wdata` = 4× byte.
  - SH: `mem_wstrb` = `addr[1]` ? 1100 : 0011, `mem_wdata` = 2× half.
  - SW: `mem_wstrb` = 1111, `mem_wdata` = full word.
- For loads, `mem_wstrb` = 0000.
- RESP: on `mem_rvalid`, extract the lane `mem_rdata >> (8*addr[1:0])`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - Then register the write-back and return to IDLE.
- `mem_rvalid` is ignored outside RESP, including the handshake cycle itself.
- `wb_valid` is suppressed when rd = 0. The bus access still occurs.

## Timing
- Reset (synchronous, wins over everything):
  - State goes to IDLE.
  - `mem_valid`, `mem_we`, `mem_wstrb`, `wb_valid`, `err` and `stall` go to 0.
  - `mem_addr`, `mem_wdata`, `wb_rd` and `wb_data` go to 0.
- Reset mid-transaction abandons the op. A late `mem_rvalid` after reset is ignored.
- Acceptance at cycle T puts `mem_valid` = 1 at T+1.
- With zero-wait memory (`mem_ready` high at T+1), a store sets `req_ready` = 1 again at T+2.
- For a load, `mem_rvalid` at cycle R produces `wb_valid` at R+1 and `req_ready` = 1 at R+1.
- Minimum load latency is acceptance to `wb_valid` in 3 cycles.
- `stall` = 1 from T+1 until the cycle the FSM is back in IDLE.
- `err` pulses at T+1. `req_ready` stays 1 throughout.
- Back-to-back operation: a new request may be accepted in the same cycle `wb_valid` pulses.

## Structure
- Shared package `lsu_pkg` holds:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state enum (IDLE, REQ, RESP).
  - Store strobe width constant.
- Sub-module `lsu_align` is purely combinational. It contains:
  - Store strobe/data formatting.
  - Load lane extraction and extension.
  - Legality check.
- The FSM and registers live in `load_store_unit`.

## Test plan
- SW to address 0x100 with data 0xDEADBEEF, `mem_ready` = 1:
  - `mem_addr` = 0x100, `wstrb` = 1111, `wdata` = 0xDEADBEEF at T+1.
  - `req_ready` = 1 at T+2.
  - No `wb_valid`.
- SB to address 0x103 with data 0x000000A5:
  - `wstrb` = 1000, `wdata` = 0xA5A5A5A5, `mem_addr` = 0x100.
- LB rd = 5 from address 0x102, `rdata` = 0x12F03456, `mem_rvalid` 2 cycles after handshake:
  - `wb_data` = 0xFFFFFFF0, `wb_rd` = 5, single `wb_valid` pulse.
- Same op as LBU:
  - `wb_data` = 0x000000F0.
- LH at address 0x101:
  - `err` pulse at T+1, `mem_valid` stays 0, `stall` = 0.
- `mem_ready` held low 4 cycles, then reset asserted during REQ:
  - `mem_valid` held stable until reset.
  - All outputs 0 after reset.
  - A subsequent `mem_rvalid` produces no `wb_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit.
package lsu_pkg;

  localparam int STRB_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request, data-memory bus and write-back signals of the LSU.
interface load_store_unit_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              stall;
  logic              err;

  // LSU side
  modport slave (
    input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output wb_valid, wb_rd, wb_data, stall, err
  );

  // pipeline / memory side
  modport master (
    output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  wb_valid, wb_rd, wb_data, stall, err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational store formatting, legality check and load lane extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic              load_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [31:0]       wdata_i,
  output logic              legal_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [31:0]       wdata_o,
  input  logic [2:0]        rsp_funct3_i,
  input  logic [1:0]        rsp_lane_i,
  input  logic [31:0]       rdata_i,
  output logic [31:0]       ldata_o
);

  logic [31:0] lane_w;

  always_comb begin
    legal_o = 1'b0;
    if (load_i) begin
      case (funct3_i)
        F3_LB, F3_LBU: legal_o = 1'b1;
        F3_LH, F3_LHU: legal_o = ~addr_lo_i[0];
        F3_LW:         legal_o = (addr_lo_i == 2'b00);
        default:       legal_o = 1'b0;
      endcase
    end else begin
      case (funct3_i)
        F3_SB:   legal_o = 1'b1;
        F3_SH:   legal_o = ~addr_lo_i[0];
        F3_SW:   legal_o = (addr_lo_i == 2'b00);
        default: legal_o = 1'b0;
      endcase
    end
  end

  // store data is replicated across lanes so the strobe alone selects bytes
  always_comb begin
    wstrb_o = '0;
    wdata_o = wdata_i;
    case (funct3_i)
      F3_SB: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_SH: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      F3_SW:   wstrb_o = 4'b1111;
      default: wstrb_o = '0;
    endcase
  end

  always_comb begin
    lane_w = rdata_i >> {rsp_lane_i, 3'b000};
    case (rsp_funct3_i)
      F3_LB:   ldata_o = {{24{lane_w[7]}}, lane_w[7:0]};
      F3_LH:   ldata_o = {{16{lane_w[15]}}, lane_w[15:0]};
      F3_LBU:  ldata_o = {24'd0, lane_w[7:0]};
      F3_LHU:  ldata_o = {16'd0, lane_w[15:0]};
      default: ldata_o = lane_w;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding op, valid/ready data-memory bus, write-back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] REQ  = 2'(ST_REQ);
  localparam logic [1:0] RESP = 2'(ST_RESP);

  logic [1:0]        state_q, state_d;
  logic              load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [31:0]       wdata_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              err_q;

  logic              accept, legal, rsp_fire;
  logic [STRB_W-1:0] fmt_strb;
  logic [31:0]       fmt_wdata, ldata;

  lsu_align u_align (
    .load_i       (bus.req_load),
    .funct3_i     (bus.req_funct3),
    .addr_lo_i    (bus.req_addr[1:0]),
    .wdata_i      (bus.req_wdata),
    .legal_o      (legal),
    .wstrb_o      (fmt_strb),
    .wdata_o      (fmt_wdata),
    .rsp_funct3_i (funct3_q),
    .rsp_lane_i   (lane_q),
    .rdata_i      (bus.mem_rdata),
    .ldata_o      (ldata)
  );

  assign accept   = bus.req_valid && (state_q == IDLE);
  // rvalid only counts once the request handshake has already moved us to RESP
  assign rsp_fire = (state_q == RESP) && bus.mem_rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && legal) state_d = REQ;
      REQ:     if (bus.mem_ready) state_d = load_q ? RESP : IDLE;
      RESP:    if (bus.mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      funct3_q   <= '0;
      lane_q     <= '0;
      rd_q       <= '0;
      mem_addr_q <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= accept && !legal;
      wb_valid_q <= rsp_fire && (rd_q != 5'd0);
      if (accept && legal) begin
        load_q     <= bus.req_load;
        funct3_q   <= bus.req_funct3;
        lane_q     <= bus.req_addr[1:0];
        rd_q       <= bus.req_rd;
        mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        wstrb_q    <= bus.req_load ? '0 : fmt_strb;
        wdata_q    <= bus.req_load ? '0 : fmt_wdata;
      end
      if (rsp_fire) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= ldata;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.stall     = (state_q != IDLE);
  assign bus.mem_valid = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) && !load_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.err       = err_q;

endmodule
